// File: rtl/div_unit_cpu.sv
// Multi-cycle unsigned restoring divider that sits beside the single-cycle ALU.
// The controller pulses start with the operands, waits for done, then reads quotient and remainder.
module div_unit_cpu #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_zero
);

   // state  | meaning
   // S_IDLE | waiting for start; results held
   // S_RUN  | one restoring step per clock, WIDTH steps
   // S_DONE | done pulse for one cycle, then back to idle
   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_t           state;
   logic [WIDTH-1:0] p;
   logic [WIDTH-1:0] q;
   logic [WIDTH-1:0] d;
   logic [CW-1:0]    count;

   logic [WIDTH:0]   p_trial;
   logic             ge;
   logic [WIDTH-1:0] p_nx;
   logic [WIDTH-1:0] q_nx;

   // The partial remainder is always below the divisor after a step, so only
   // the shifted trial value needs the extra bit to avoid overflow.
   always_comb begin
      p_trial = {p, q[WIDTH-1]};
      ge      = (p_trial >= {1'b0, d});
      p_nx    = ge ? WIDTH'(p_trial - {1'b0, d}) : p_trial[WIDTH-1:0];
      q_nx    = {q[WIDTH-2:0], ge};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         busy      <= 1'b0;
         done      <= 1'b0;
         quotient  <= '0;
         remainder <= '0;
         div_zero  <= 1'b0;
         p         <= '0;
         q         <= '0;
         d         <= '0;
         count     <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  q     <= dividend;
                  d     <= divisor;
                  p     <= '0;
                  count <= '0;
                  if (divisor == '0) begin
                     state     <= S_DONE;
                     done      <= 1'b1;
                     quotient  <= '1;
                     remainder <= dividend;
                     div_zero  <= 1'b1;
                  end else begin
                     state <= S_RUN;
                     busy  <= 1'b1;
                  end
               end
            end
            S_RUN: begin
               p     <= p_nx;
               q     <= q_nx;
               count <= count + CW'(1);
               if (count == LAST) begin
                  state     <= S_DONE;
                  busy      <= 1'b0;
                  done      <= 1'b1;
                  quotient  <= q_nx;
                  remainder <= p_nx;
                  div_zero  <= 1'b0;
               end
            end
            S_DONE: begin
               done  <= 1'b0;
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_div_unit_cpu.sv
// Directed and randomised checks for the restoring divider, sampled 1ns after each rising edge.
module tb_div_unit_cpu;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [15:0] dividend;
   logic [15:0] divisor;
   logic        busy;
   logic        done;
   logic [15:0] quotient;
   logic [15:0] remainder;
   logic        div_zero;

   int tests = 0;
   int fails = 0;

   div_unit_cpu #(.WIDTH(16)) dut (
      .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
      .busy(busy), .done(done), .quotient(quotient), .remainder(remainder), .div_zero(div_zero)
   );

   always #5 clk = ~clk;

   // Issues one operation and waits (bounded) for done; lat = -1 on timeout.
   // Returns with the DUT back in IDLE, so the next call can start immediately.
   task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                         output logic [15:0] rq, output logic [15:0] rr, output logic rdz,
                         output int lat, output int busy_cyc, output logic held, output logic pulse1);
      logic [15:0] pq, pr;
      @(negedge clk);
      dividend = a; divisor = b; start = 1'b1;
      pq = quotient; pr = remainder;
      @(posedge clk); #1;
      start = 1'b0; dividend = 16'hDEAD; divisor = 16'hBEEF;
      lat = -1; busy_cyc = 0; held = 1'b1;
      for (int k = 0; k < 40; k++) begin
         if (done) begin lat = k; break; end
         if (busy) busy_cyc++;
         if (quotient !== pq || remainder !== pr) held = 1'b0;
         @(posedge clk); #1;
      end
      rq = quotient; rr = remainder; rdz = div_zero;
      @(posedge clk); #1;
      pulse1 = (done === 1'b0);
   endtask

   task automatic test_reset;
      rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
      repeat (3) @(posedge clk);
      #1;
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
      tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done got %b want 0", done); end
      tests++; if (quotient !== 16'h0) begin fails++; $display("FAIL reset_q got %h want 0000", quotient); end
      tests++; if (remainder !== 16'h0) begin fails++; $display("FAIL reset_r got %h want 0000", remainder); end
      tests++; if (div_zero !== 1'b0) begin fails++; $display("FAIL reset_dz got %b want 0", div_zero); end
      @(negedge clk); rst = 1'b0;
   endtask

   task automatic test_basic;
      logic [15:0] rq, rr; logic rdz, held, p1; int lat, bc;
      run_op(16'd100, 16'd7, rq, rr, rdz, lat, bc, held, p1);
      tests++; if (lat !== 16) begin fails++; $display("FAIL basic_latency got %0d want 16", lat); end
      tests++; if (bc !== 16) begin fails++; $display("FAIL basic_busy_cycles got %0d want 16", bc); end
      tests++; if (rq !== 16'd14) begin fails++; $display("FAIL basic_q got %0d want 14", rq); end
      tests++; if (rr !== 16'd2) begin fails++; $display("FAIL basic_r got %0d want 2", rr); end
      tests++; if (rdz !== 1'b0) begin fails++; $display("FAIL basic_dz got %b want 0", rdz); end
      tests++; if (!p1) begin fails++; $display("FAIL basic_done_width got >1 want 1"); end
   endtask

   task automatic test_vectors;
      logic [15:0] va [6] = '{16'hFFFF, 16'hFFFF, 16'd3,  16'd0, 16'h8000, 16'd1};
      logic [15:0] vb [6] = '{16'd1,   16'hFFFF, 16'd10, 16'd5, 16'd3,    16'hFFFF};
      logic [15:0] eq [6] = '{16'hFFFF, 16'd1,   16'd0,  16'd0, 16'd10922, 16'd0};
      logic [15:0] er [6] = '{16'd0,   16'd0,    16'd3,  16'd0, 16'd2,    16'd1};
      logic [15:0] rq, rr; logic rdz, held, p1; int lat, bc;
      for (int i = 0; i < 6; i++) begin
         run_op(va[i], vb[i], rq, rr, rdz, lat, bc, held, p1);
         tests++;
         if (rq !== eq[i] || rr !== er[i] || rdz !== 1'b0 || lat !== 16) begin
            fails++;
            $display("FAIL vec%0d %h/%h got q=%h r=%h dz=%b lat=%0d want q=%h r=%h dz=0 lat=16",
                     i, va[i], vb[i], rq, rr, rdz, lat, eq[i], er[i]);
         end
      end
   endtask

   task automatic test_div_zero;
      logic [15:0] rq, rr; logic rdz, held, p1; int lat, bc;
      run_op(16'd5, 16'd0, rq, rr, rdz, lat, bc, held, p1);
      tests++; if (lat !== 0) begin fails++; $display("FAIL dz_latency got %0d want 0", lat); end
      tests++; if (bc !== 0) begin fails++; $display("FAIL dz_busy got %0d want 0", bc); end
      tests++; if (rq !== 16'hFFFF || rr !== 16'd5) begin fails++; $display("FAIL dz_result got q=%h r=%h want q=ffff r=0005", rq, rr); end
      tests++; if (rdz !== 1'b1) begin fails++; $display("FAIL dz_flag got %b want 1", rdz); end
      tests++; if (!p1) begin fails++; $display("FAIL dz_done_width got >1 want 1"); end
      run_op(16'd9, 16'd3, rq, rr, rdz, lat, bc, held, p1);
      tests++;
      if (rq !== 16'd3 || rr !== 16'd0 || rdz !== 1'b0) begin
         fails++; $display("FAIL dz_followup got q=%0d r=%0d dz=%b want q=3 r=0 dz=0", rq, rr, rdz);
      end
   endtask

   task automatic test_ignored_start;
      int ndone = 0;
      @(negedge clk); dividend = 16'd50; divisor = 16'd5; start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk); dividend = 16'd8; divisor = 16'd2; start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      tests++; if (busy !== 1'b1) begin fails++; $display("FAIL ign_busy got %b want 1", busy); end
      tests++; if (quotient !== 16'd3) begin fails++; $display("FAIL ign_hold_q got %0d want 3", quotient); end
      for (int k = 0; k < 30; k++) begin
         if (done) ndone++;
         @(posedge clk); #1;
      end
      tests++; if (ndone !== 1) begin fails++; $display("FAIL ign_done_count got %0d want 1", ndone); end
      tests++;
      if (quotient !== 16'd10 || remainder !== 16'd0) begin
         fails++; $display("FAIL ign_result got q=%0d r=%0d want q=10 r=0", quotient, remainder);
      end
   endtask

   task automatic test_back_to_back;
      logic [15:0] rq, rr; logic rdz, held, p1; int lat, bc;
      @(negedge clk); dividend = 16'd20; divisor = 16'd4; start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      lat = -1;
      for (int k = 0; k < 40; k++) begin
         if (done) begin lat = k; break; end
         @(posedge clk); #1;
      end
      tests++; if (lat !== 16) begin fails++; $display("FAIL b2b_latency got %0d want 16", lat); end
      start = 1'b1; dividend = 16'd7; divisor = 16'd7;
      @(posedge clk); #1; start = 1'b0;
      tests++;
      if (busy !== 1'b0 || done !== 1'b0 || quotient !== 16'd5) begin
         fails++; $display("FAIL b2b_start_in_done got busy=%b done=%b q=%0d want busy=0 done=0 q=5", busy, done, quotient);
      end
      run_op(16'd7, 16'd7, rq, rr, rdz, lat, bc, held, p1);
      tests++;
      if (rq !== 16'd1 || rr !== 16'd0 || lat !== 16 || !held) begin
         fails++; $display("FAIL b2b_next got q=%0d r=%0d lat=%0d held=%b want q=1 r=0 lat=16 held=1", rq, rr, lat, held);
      end
   endtask

   task automatic test_reset_mid_run;
      int lat = -1;
      @(negedge clk); dividend = 16'd1000; divisor = 16'd3; start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      repeat (7) @(posedge clk);
      @(negedge clk); rst = 1'b1;
      @(posedge clk); #1;
      tests++;
      if (busy !== 1'b0 || done !== 1'b0 || quotient !== 16'd0 || remainder !== 16'd0 || div_zero !== 1'b0) begin
         fails++;
         $display("FAIL rst_mid got busy=%b done=%b q=%h r=%h dz=%b want all 0", busy, done, quotient, remainder, div_zero);
      end
      @(negedge clk); rst = 1'b0; dividend = 16'd1000; divisor = 16'd3; start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      tests++; if (busy !== 1'b1) begin fails++; $display("FAIL rst_restart_busy got %b want 1", busy); end
      for (int k = 1; k < 40; k++) begin
         @(posedge clk); #1;
         if (done) begin lat = k; break; end
      end
      tests++;
      if (lat !== 16 || quotient !== 16'd333 || remainder !== 16'd1) begin
         fails++; $display("FAIL rst_restart got lat=%0d q=%0d r=%0d want lat=16 q=333 r=1", lat, quotient, remainder);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_random;
      logic [15:0] corners [4] = '{16'h0000, 16'h0001, 16'h8000, 16'hFFFF};
      logic [15:0] a, b, xq, xr, rq, rr; logic xdz, rdz, held, p1; int lat, bc, xlat;
      for (int i = 0; i < 600; i++) begin
         a = (i % 3 == 0) ? corners[$urandom_range(0, 3)] : 16'($urandom);
         b = (i % 4 == 0) ? corners[$urandom_range(0, 3)] : 16'($urandom);
         if (i % 5 == 1) b = 16'($urandom_range(1, 20));
         if (b == 16'd0) begin xq = 16'hFFFF; xr = a; xdz = 1'b1; xlat = 0; end
         else begin xq = a / b; xr = a % b; xdz = 1'b0; xlat = 16; end
         run_op(a, b, rq, rr, rdz, lat, bc, held, p1);
         tests++;
         if (rq !== xq || rr !== xr || rdz !== xdz || lat !== xlat || !held || !p1) begin
            fails++;
            $display("FAIL rand%0d %h/%h got q=%h r=%h dz=%b lat=%0d held=%b pulse1=%b want q=%h r=%h dz=%b lat=%0d held=1 pulse1=1",
                     i, a, b, rq, rr, rdz, lat, held, p1, xq, xr, xdz, xlat);
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_vectors();
      test_div_zero();
      test_ignored_start();
      test_back_to_back();
      test_reset_mid_run();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
